// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access at a time between the execute stage
// and a 32-bit block RAM, with lane-masked stores, extended loads and fault responses.
module lsu #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_fault,
  output logic          mem_ren,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_rd_valid,
  output logic          mem_wen,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP, S_FAULT
  } state_t;

  state_t        r_state;
  logic          r_rsp_valid;
  logic          r_rsp_fault;
  logic [31:0]   r_rsp_rdata;
  logic          r_mem_ren;
  logic          r_mem_wen;
  logic [AW-1:0] r_mem_addr;
  logic [31:0]   r_mem_wdata;
  logic [3:0]    r_mem_wmask;
  logic [1:0]    r_off;
  logic [1:0]    r_size;
  logic          r_signed;

  logic          w_fault;
  logic [3:0]    w_wmask;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load;

  assign w_fault = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

  // Mask bit 3-k enables lane k, so masks read MSB-first from offset 0.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    w_wmask = 4'b1111;
    w_wdata = req_wdata;
    case (req_size)
      2'd0: begin
        w_wmask = 4'b1000 >> req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        w_wmask = req_addr[1] ? 4'b0011 : 4'b1100;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_half = mem_rdata[{r_off[1], 4'b0000} +: 16];
    case (r_size)
      2'd0:    w_load = {{24{r_signed & w_byte[7]}}, w_byte};
      2'd1:    w_load = {{16{r_signed & w_half[15]}}, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_rsp_rdata <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_off       <= '0;
      r_size      <= '0;
      r_signed    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_fault <= 1'b0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      case (r_state)
        S_IDLE: if (req_valid) begin
          r_off    <= req_addr[1:0];
          r_size   <= req_size;
          r_signed <= req_signed;
          if (w_fault) begin
            r_state     <= S_FAULT;
            r_rsp_valid <= 1'b1;
            r_rsp_fault <= 1'b1;
            r_rsp_rdata <= '0;
          end else begin
            r_mem_addr <= {req_addr[AW-1:2], 2'b00};
            if (req_we) begin
              r_state     <= S_WRITE;
              r_mem_wen   <= 1'b1;
              r_mem_wdata <= w_wdata;
              r_mem_wmask <= w_wmask;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
            end else begin
              r_state   <= S_READ;
              r_mem_ren <= 1'b1;
            end
          end
        end
        S_READ: r_state <= S_WAIT;
        S_WAIT: if (mem_rd_valid) begin
          r_state     <= S_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_load;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_fault = r_rsp_fault;
  assign rsp_rdata = r_rsp_rdata;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: a byte-array reference model predicts responses and RAM
// strobes at issue time; a negedge monitor compares whatever the unit presents.
module tb_lsu;

  typedef struct {
    logic        fault;
    logic [31:0] rdata;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } mop_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [12:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;
  logic        mem_ren, mem_wen, mem_rd_valid;
  logic [12:0] mem_addr;
  logic [31:0] mem_rdata, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        ram_rdv = 1'b0;
  logic        inj_rdv = 1'b0;

  logic [31:0] ram [0:2047] = '{default: 32'h0};
  logic [7:0]  ref_mem [0:8191] = '{default: 8'h0};

  rsp_t rspq[$];
  mop_t mopq[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  lsu #(.AW(13)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
    .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .mem_rd_valid(mem_rd_valid), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask)
  );

  // Block RAM: read data one cycle after mem_ren; lane k written when mask[3-k].
  always @(posedge clk) begin
    ram_rdv <= mem_ren;
    if (mem_ren) mem_rdata <= ram[mem_addr[12:2]];
    if (mem_wen)
      for (int k = 0; k < 4; k++)
        if (mem_wmask[3-k]) ram[mem_addr[12:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
  end
  assign mem_rd_valid = ram_rdv | inj_rdv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: memory as bytes, access = nb consecutive bytes from addr.
  task automatic ref_model(input logic we, input logic [1:0] size, input logic sgn,
                           input logic [12:0] addr, input logic [31:0] wd);
    int          nb;
    logic [31:0] v;
    mop_t        m;
    rsp_t        r;
    bit          flt;
    flt = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    if (flt) begin
      r.fault = 1'b1;
      r.rdata = 32'h0;
      rspq.push_back(r);
      return;
    end
    nb      = 1 << size;
    m.we    = we;
    m.addr  = addr & 13'h1FFC;
    m.wdata = 32'h0;
    m.wmask = 4'h0;
    r.fault = 1'b0;
    if (we) begin
      for (int i = 0; i < nb; i++) begin
        ref_mem[int'(addr) + i] = wd[8*i +: 8];
        m.wmask[3 - (int'(addr[1:0]) + i)] = 1'b1;
      end
      for (int k = 0; k < 4; k++) m.wdata[8*k +: 8] = wd[8*(k % nb) +: 8];
      r.rdata = 32'h0;
    end else begin
      v = 32'h0;
      for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
      if (sgn && nb < 4 && v[8*nb-1])
        for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
      r.rdata = v;
    end
    mopq.push_back(m);
    rspq.push_back(r);
  endtask

  // Monitor: every strobe and every response must match the head of its queue.
  always @(negedge clk) begin
    mop_t m;
    rsp_t r;
    if (!rst) begin
      if (mem_wen || mem_ren) begin
        if (mopq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_strobe: got ren=%0b wen=%0b expected none", mem_ren, mem_wen);
        end else begin
          m = mopq.pop_front();
          check("mem_wen", 32'(mem_wen), 32'(m.we));
          check("mem_ren", 32'(mem_ren), 32'(!m.we));
          check("mem_addr", 32'(mem_addr), 32'(m.addr));
          if (m.we) begin
            check("mem_wdata", mem_wdata, m.wdata);
            check("mem_wmask", 32'(mem_wmask), 32'(m.wmask));
          end
        end
      end
      if (rsp_valid) begin
        if (rspq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL spurious_rsp: got rsp_valid=1 rdata=0x%08h expected none", rsp_rdata);
        end else begin
          r = rspq.pop_front();
          check("rsp_fault", 32'(rsp_fault), 32'(r.fault));
          check("rsp_rdata", rsp_rdata, r.rdata);
        end
      end
    end
  end

  // Called at a negedge with the unit idle; returns at the negedge it is idle again.
  task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [12:0] addr, input logic [31:0] wd, input bit hold);
    int  busy, rsp_at, waited;
    bit  is_load, flt;
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    waited = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    ref_model(we, size, sgn, addr, wd);
    #1;
    req_valid = hold;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = 13'($urandom); req_wdata = $urandom;
    flt = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    is_load = !we && !flt;
    busy = 0;
    rsp_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (rsp_valid && rsp_at == 0) rsp_at = c;
      if (req_ready) break;
      busy++;
    end
    check("rsp_latency", 32'(rsp_at), is_load ? 32'd3 : 32'd1);
    check("busy_cycles", 32'(busy), is_load ? 32'd3 : 32'd1);
  endtask

  task automatic reset_midflight();
    mop_t m;
    req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 13'h010;
    req_wdata = 32'h0; req_valid = 1'b1;
    @(posedge clk);
    m.we = 1'b0; m.addr = 13'h010; m.wdata = 32'h0; m.wmask = 4'h0;
    mopq.push_back(m);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    inj_rdv = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_ren", 32'(mem_ren), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1 inj_rdv = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_idle_after_stale", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0]  sz;
    logic [12:0] a;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_signed = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_fault", 32'(rsp_fault), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_mem_ren", 32'(mem_ren), 32'd0);
    check("reset_mem_wen", 32'(mem_wen), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    check("reset_mem_wmask", 32'(mem_wmask), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_req(1'b1, 2'd2, 1'b0, 13'h010, 32'h12345678, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 13'h010, 32'h0, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 13'h013, 32'h000000AB, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 13'h013, 32'h0, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 13'h013, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 13'h016, 32'h00008001, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 13'h016, 32'h0, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 13'h016, 32'h0, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 13'h012, 32'h0, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 13'h011, 32'hFFFF, 1'b0);
    do_req(1'b0, 2'd3, 1'b0, 13'h000, 32'h0, 1'b0);

    // Back-to-back loads with req_valid held and inputs scrambled while busy.
    do_req(1'b0, 2'd2, 1'b0, 13'h010, 32'h0, 1'b1);
    do_req(1'b0, 2'd1, 1'b1, 13'h014, 32'h0, 1'b1);
    do_req(1'b0, 2'd0, 1'b1, 13'h013, 32'h0, 1'b1);
    req_valid = 1'b0;

    reset_midflight();

    inj_rdv = 1'b1;
    @(negedge clk);
    inj_rdv = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stale_rdv_ready", 32'(req_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7 && sz != 2'd3) a = a & ~((13'd1 << sz) - 13'd1);
      do_req(1'($urandom), sz, 1'($urandom), a, $urandom, 1'($urandom));
    end
    req_valid = 1'b0;

    repeat (6) @(negedge clk);
    check("rsp_queue_drained", 32'(rspq.size()), 32'd0);
    check("mem_queue_drained", 32'(mopq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the CPU execute stage and the on-chip block RAM. Accepts one byte, halfword or word load/store at a time over a valid/ready handshake, drives the RAM's read/write strobes, lane-masked write data and byte mask, then returns aligned and extended load data as a single-cycle response. Misaligned or illegal-size accesses fault without touching memory.

## Interface
- AW, 13: byte address width. Matches the RAM's 13-bit byte address.

- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit idle and able to accept
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  AW  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse; no backpressure
- rsp_rdata  out  32  load result; 0 for stores and faults
- rsp_fault  out  1  qualifies rsp_valid: misaligned or illegal size
- mem_ren  out  1  RAM read strobe
- mem_addr  out  AW  RAM byte address, low 2 bits forced to 0
- mem_rdata  in  32  RAM read data
- mem_rd_valid  in  1  RAM read data valid (one cycle after mem_ren)
- mem_wen  out  1  RAM write strobe
- mem_wdata  out  32  RAM write data, lane-replicated
- mem_wmask  out  4  byte-lane enables, reversed order (see Operation)

## Operation
- Lane k = byte at address offset k = mem bits [8k+7:8k]. Lane k is written when mem_wmask[3-k] = 1.
- Store masks. Byte at offset k: only bit 3-k set. Half at offset 0: 4'b1100. Half at offset 2: 4'b0011. Word: 4'b1111.
- Store data. Byte: {4{wdata[7:0]}}. Half: {2{wdata[15:0]}}. Word: wdata.
- Load extract. Byte: mem_rdata lane addr[1:0]. Half: mem_rdata[16*addr[1]+15:16*addr[1]]. Word: full 32 bits. Byte and half are extended to 32 bits per req_signed.
- Fault condition:
  - req_size == 3, or
  - half with addr[0] = 1, or
  - word with addr[1:0] != 0.
- FSM states: IDLE, WRITE, READ, WAIT, RESP, FAULT.
  - IDLE: req_ready = 1. On req_valid, latch the request. Fault condition → FAULT. Otherwise req_we → WRITE, else → READ.
  - WRITE: mem_wen = 1 with latched addr/wdata/wmask; rsp_valid = 1, rsp_fault = 0, rsp_rdata = 0 → IDLE.
  - READ: mem_ren = 1 for exactly one cycle → WAIT.
  - WAIT: all strobes 0. When mem_rd_valid = 1, register the extracted/extended data → RESP. Otherwise stay in WAIT, with no timeout.
  - RESP: rsp_valid = 1 with registered data → IDLE.
  - FAULT: rsp_valid = 1, rsp_fault = 1, rsp_rdata = 0; no mem strobe → IDLE.
- req_ready = (state == IDLE). Requests are never accepted in the cycle a response is driven.
- mem_rd_valid arriving outside WAIT is ignored.
- All outputs except req_ready are registered.

## Timing
- Accept edge = rising edge with req_valid & req_ready. Call the cycle after it C1.
- Store: mem_wen and rsp_valid both high in C1. Next accept possible at the end of C2 (2 cycles per store).
- Load: mem_ren high in C1, mem_rd_valid high in C2, rsp_valid high in C3. Next accept at the end of C4.
- Fault: rsp_valid/rsp_fault high in C1.
- Reset values: state IDLE; req_ready 1; rsp_valid, rsp_fault, mem_ren, mem_wen 0; rsp_rdata, mem_addr, mem_wdata, mem_wmask 0.
- Reset mid-operation abandons the access:
  - no response is ever emitted for it;
  - strobes are 0 from the cycle after reset is sampled;
  - a stale mem_rd_valid after reset is ignored.
- Request inputs are sampled only at the accept edge. Changes while busy have no effect.

## Test plan
- Word store 0x12345678 @0x010, then unsigned word load @0x010 → store: mem_wmask 4'b1111, rsp_valid in C1. Load: rsp_rdata 0x12345678 in C3.
- Byte store 0xAB @0x013 → mem_wdata 0xABABABAB, mem_wmask 4'b0001. Signed byte load @0x013 → 0xFFFFFFAB. Unsigned → 0x000000AB.
- Half store 0x8001 @0x016 → mem_wmask 4'b0011, mem_addr 0x014. Signed half load → 0xFFFF8001. Unsigned → 0x00008001.
- Word load @0x012, half store @0x011, and size 3 @0x000 → each: rsp_fault = 1, rsp_rdata = 0 in C1; mem_ren/mem_wen never asserted.
- req_valid held high with back-to-back loads → req_ready low from C1 to C3. Second request accepted only at the end of C4. Inputs changed mid-flight do not alter the first response.
- Assert rst in WAIT, then pulse mem_rd_valid after reset → no rsp_valid; req_ready = 1, all strobes 0 the cycle after rst.
